// File: rtl/vga_timing_ctrl_if.sv
// Raster timing bus between the VGA sequencer and the pixel generator / pins.
interface vga_timing_ctrl_if;
  logic       run;
  logic       busy;
  logic       pix_tick;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       valid;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;

  // Sequencer side: takes run, drives the raster.
  modport master (
    input  run,
    output busy, pix_tick, h_cnt, v_cnt, valid, hsync, vsync, line_start, frame_start
  );

  // Consumer side: drives run, observes the raster.
  modport slave (
    output run,
    input  busy, pix_tick, h_cnt, v_cnt, valid, hsync, vsync, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: pixel-rate divider, h/v counters, sync and framing strobes,
// with run/stop control that only starts and stops on frame boundaries.
module vga_timing_ctrl #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned H_ACT   = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_ACT   = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33
) (
  input  logic               clk,
  input  logic               rst_n,
  vga_timing_ctrl_if.master  bus
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_ACT_C  = 10'(H_ACT);
  localparam logic [9:0] H_SYNC_B = 10'(H_ACT + H_FP);
  localparam logic [9:0] H_SYNC_E = 10'(H_ACT + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST   = 10'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT_C  = 10'(V_ACT);
  localparam logic [9:0] V_SYNC_B = 10'(V_ACT + V_FP);
  localparam logic [9:0] V_SYNC_E = 10'(V_ACT + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_ACT + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             busy_q, busy_d;
  logic             tick_q, tick_d;
  logic             valid_q, valid_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             lstart_q, lstart_d;
  logic             fstart_q, fstart_d;
  logic             tick;
  logic             frame_end;

  // Next state of the sequencer; every output is derived from the next position so
  // that it is registered alongside the counters and describes what they present.
  always_comb begin
    state_d   = state_q;
    div_d     = '0;
    h_d       = '0;
    v_d       = '0;
    tick      = (state_q != ST_IDLE) && (div_q == DIV_LAST);
    frame_end = tick && (h_q == H_LAST) && (v_q == V_LAST);

    unique case (state_q)
      ST_IDLE: if (bus.run) state_d = ST_RUN;
      ST_RUN:  if (!bus.run) state_d = ST_STOP;
      ST_STOP: begin
        // A late re-assertion of run wins over the pending stop.
        if (bus.run)        state_d = ST_RUN;
        else if (frame_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Counting continues in RUN and STOPPING; entry from IDLE and exit to IDLE land on zero.
    if ((state_q != ST_IDLE) && (state_d != ST_IDLE)) begin
      h_d = h_q;
      v_d = v_q;
      if (tick) begin
        div_d = '0;
        if (h_q == H_LAST) begin
          h_d = 10'd0;
          v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        end else begin
          h_d = h_q + 10'd1;
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    busy_d   = (state_d != ST_IDLE);
    tick_d   = busy_d && (div_d == DIV_LAST);
    valid_d  = busy_d && (h_d < H_ACT_C) && (v_d < V_ACT_C);
    hsync_d  = !(busy_d && (h_d >= H_SYNC_B) && (h_d < H_SYNC_E));
    vsync_d  = !(busy_d && (v_d >= V_SYNC_B) && (v_d < V_SYNC_E));
    // div_d == 0 marks the first clk a position is presented.
    lstart_d = busy_d && (div_d == '0) && (h_d == 10'd0);
    fstart_d = lstart_d && (v_d == 10'd0);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      h_q      <= '0;
      v_q      <= '0;
      busy_q   <= 1'b0;
      tick_q   <= 1'b0;
      valid_q  <= 1'b0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      lstart_q <= 1'b0;
      fstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      h_q      <= h_d;
      v_q      <= v_d;
      busy_q   <= busy_d;
      tick_q   <= tick_d;
      valid_q  <= valid_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      lstart_q <= lstart_d;
      fstart_q <= fstart_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.pix_tick    = tick_q;
  assign bus.h_cnt       = h_q;
  assign bus.v_cnt       = v_q;
  assign bus.valid       = valid_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.line_start  = lstart_q;
  assign bus.frame_start = fstart_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench: full-size timing on line level, reduced geometries for frame,
// stop/resume, async reset and the CLK_DIV=1 corner.
module tb_vga_timing_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b, rst_s, rst_t;

  vga_timing_ctrl_if big_if();
  vga_timing_ctrl_if sml_if();
  vga_timing_ctrl_if tny_if();

  // 800x525, CLK_DIV=4
  vga_timing_ctrl u_big (.clk(clk), .rst_n(rst_b), .bus(big_if.master));

  // 16x10 total, CLK_DIV=2: line 32 clks, frame 320 clks
  vga_timing_ctrl #(
    .CLK_DIV(2), .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACT(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_sml (.clk(clk), .rst_n(rst_s), .bus(sml_if.master));

  // 7x6 total, CLK_DIV=1: frame 42 clks
  vga_timing_ctrl #(
    .CLK_DIV(1), .H_ACT(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACT(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_tny (.clk(clk), .rst_n(rst_t), .bus(tny_if.master));

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Poll the small instance until it presents (h,v); bounded.
  task automatic wait_sml(input logic [9:0] h, input logic [9:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (sml_if.h_cnt == h && sml_if.v_cnt == v) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  int fs[$];
  int cnt_a, cnt_b, cnt_c, cnt_d, cnt_e;
  logic [9:0] last_h, last_v;
  bit ok;

  initial begin
    rst_b = 1'b0; rst_s = 1'b0; rst_t = 1'b0;
    big_if.run = 1'b1; sml_if.run = 1'b0; tny_if.run = 1'b0;

    // Reset held with run=1: nothing moves.
    repeat (3) begin
      @(negedge clk);
      check("rst_busy",  big_if.busy,  0);
      check("rst_h",     big_if.h_cnt, 0);
      check("rst_v",     big_if.v_cnt, 0);
      check("rst_valid", big_if.valid, 0);
      check("rst_hsync", big_if.hsync, 1);
      check("rst_vsync", big_if.vsync, 1);
    end
    check("rst_fstart", big_if.frame_start, 0);
    check("rst_ptick",  big_if.pix_tick, 0);

    // Release; run already high so clk 0 presents (0,0).
    rst_b = 1'b1; rst_s = 1'b1; rst_t = 1'b1;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int c = 0; c <= 3210; c++) begin
      @(negedge clk);
      if (big_if.line_start) cnt_a++;
      if (!big_if.hsync) cnt_b++;
      if (big_if.pix_tick) cnt_c++;
      if (c == 0) begin
        check("big_fs0",    big_if.frame_start, 1);
        check("big_ls0",    big_if.line_start, 1);
        check("big_valid0", big_if.valid, 1);
        check("big_busy0",  big_if.busy, 1);
        check("big_hv0",    {big_if.h_cnt, big_if.v_cnt}, 0);
      end
      if (c == 1) check("big_fs1", big_if.frame_start, 0);
      if (c == 3) check("big_tick3", big_if.pix_tick, 1);
      if (c == 3) check("big_h3", big_if.h_cnt, 0);
      if (c == 4) check("big_h4", big_if.h_cnt, 1);
      if (c == 2559) check("big_valid2559", big_if.valid, 1);
      if (c == 2560) check("big_valid2560", big_if.valid, 0);
      if (c == 2623) check("big_hs2623", big_if.hsync, 1);
      if (c == 2624) check("big_hs2624", big_if.hsync, 0);
      if (c == 3007) check("big_hs3007", big_if.hsync, 0);
      if (c == 3008) check("big_hs3008", big_if.hsync, 1);
      if (c == 3199) check("big_h3199", big_if.h_cnt, 799);
      if (c == 3199) check("big_ls3199", big_if.line_start, 0);
      if (c == 3200) begin
        check("big_ls3200", big_if.line_start, 1);
        check("big_h3200",  big_if.h_cnt, 0);
        check("big_v3200",  big_if.v_cnt, 1);
        check("big_fs3200", big_if.frame_start, 0);
      end
    end
    check("big_ls_count", cnt_a, 2);
    check("big_hs_low",   cnt_b, 384);
    check("big_ticks",    cnt_c, 802);

    // Small instance: start and run three frames.
    check("sml_idle_busy", sml_if.busy, 0);
    sml_if.run = 1'b1;
    @(negedge clk);
    fs.delete();
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
    for (int c = 0; c < 960; c++) begin
      if (sml_if.frame_start) fs.push_back(c);
      if (!sml_if.vsync) cnt_a++;
      if (sml_if.valid) cnt_b++;
      if (sml_if.line_start) cnt_c++;
      if (sml_if.valid != (sml_if.h_cnt < 10'd8 && sml_if.v_cnt < 10'd6)) cnt_d++;
      @(negedge clk);
    end
    check("sml_fs_count", fs.size(), 3);
    if (fs.size() == 3) begin
      check("sml_fs_first",  fs[0], 0);
      check("sml_fs_period", fs[1] - fs[0], 320);
      check("sml_fs_period2", fs[2] - fs[1], 320);
    end
    check("sml_vs_low",    cnt_a, 192);
    check("sml_valid_cnt", cnt_b, 288);
    check("sml_ls_count",  cnt_c, 30);
    check("sml_valid_def", cnt_d, 0);

    // Stop at (3,4): 93 positions x 2 clks remain in the frame.
    wait_sml(10'd3, 10'd4, ok);
    check("sml_wait_stop", ok, 1);
    sml_if.run = 1'b0;
    cnt_a = 0; last_h = '0; last_v = '0;
    for (int k = 0; k < 1000; k++) begin
      if (!sml_if.busy) break;
      cnt_a++;
      last_h = sml_if.h_cnt;
      last_v = sml_if.v_cnt;
      @(negedge clk);
    end
    check("sml_stop_len", cnt_a, 186);
    check("sml_stop_h", last_h, 15);
    check("sml_stop_v", last_v, 9);
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0; cnt_e = 0;
    repeat (60) begin
      if (sml_if.frame_start) cnt_a++;
      if (sml_if.busy) cnt_b++;
      if (!sml_if.hsync) cnt_c++;
      if (!sml_if.vsync) cnt_d++;
      if (sml_if.h_cnt != 0 || sml_if.v_cnt != 0) cnt_e++;
      @(negedge clk);
    end
    check("sml_idle_fs",    cnt_a, 0);
    check("sml_idle_busy2", cnt_b, 0);
    check("sml_idle_hs",    cnt_c, 0);
    check("sml_idle_vs",    cnt_d, 0);
    check("sml_idle_hv",    cnt_e, 0);

    // Restart, then a short run=0 glitch inside the frame must not disturb the raster.
    sml_if.run = 1'b1;
    @(negedge clk);
    check("sml_restart_fs", sml_if.frame_start, 1);
    fs.delete();
    cnt_a = 0;
    for (int c = 0; c < 700; c++) begin
      if (c == 100) sml_if.run = 1'b0;
      if (c == 150) sml_if.run = 1'b1;
      if (sml_if.frame_start) fs.push_back(c);
      if (!sml_if.busy) cnt_a++;
      @(negedge clk);
    end
    check("sml_res_fs_count", fs.size(), 3);
    if (fs.size() == 3) begin
      check("sml_res_p1", fs[1] - fs[0], 320);
      check("sml_res_p2", fs[2] - fs[1], 320);
    end
    check("sml_res_idle", cnt_a, 0);

    // Async reset between edges at (5,3).
    wait_sml(10'd5, 10'd3, ok);
    check("sml_wait_rst", ok, 1);
    #2 rst_s = 1'b0;
    #1;
    check("arst_busy",   sml_if.busy, 0);
    check("arst_hv",     {sml_if.h_cnt, sml_if.v_cnt}, 0);
    check("arst_valid",  sml_if.valid, 0);
    check("arst_hsync",  sml_if.hsync, 1);
    check("arst_vsync",  sml_if.vsync, 1);
    check("arst_ls",     sml_if.line_start, 0);
    check("arst_ptick",  sml_if.pix_tick, 0);
    @(negedge clk);
    check("arst_hold", sml_if.busy, 0);
    rst_s = 1'b1;
    @(negedge clk);
    check("arst_re_fs",    sml_if.frame_start, 1);
    check("arst_re_hv",    {sml_if.h_cnt, sml_if.v_cnt}, 0);
    check("arst_re_valid", sml_if.valid, 1);

    // CLK_DIV=1: one position per clk, pix_tick constant while busy.
    tny_if.run = 1'b1;
    @(negedge clk);
    cnt_a = 0;
    for (int c = 0; c < 84; c++) begin
      if (tny_if.pix_tick) cnt_a++;
      if (c == 0) check("tny_fs0", tny_if.frame_start, 1);
      if (c == 1) check("tny_h1", tny_if.h_cnt, 1);
      if (c == 3) check("tny_valid3", tny_if.valid, 1);
      if (c == 4) check("tny_valid4", tny_if.valid, 0);
      if (c == 4) check("tny_hs4", tny_if.hsync, 1);
      if (c == 5) check("tny_hs5", tny_if.hsync, 0);
      if (c == 6) check("tny_hs6", tny_if.hsync, 1);
      if (c == 7) begin
        check("tny_ls7", tny_if.line_start, 1);
        check("tny_hv7", {tny_if.h_cnt, tny_if.v_cnt}, 1);
      end
      if (c == 28) check("tny_vs28", tny_if.vsync, 0);
      if (c == 35) check("tny_vs35", tny_if.vsync, 1);
      if (c == 42) begin
        check("tny_fs42", tny_if.frame_start, 1);
        check("tny_hv42", {tny_if.h_cnt, tny_if.v_cnt}, 0);
      end
      @(negedge clk);
    end
    check("tny_ticks", cnt_a, 84);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
